// File: rtl/fir_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | fir_seq_pkg                                                                 |
// | Shared state encoding, default widths and accumulator sizing.               |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package fir_seq_pkg;

  localparam int DEFAULT_TAPS = 3;
  localparam int DEFAULT_DW   = 8;
  localparam int DEFAULT_CW   = 8;
  localparam int DEFAULT_OW   = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Headroom of clog2(TAPS) bits keeps the running sum from ever wrapping.
  function automatic int acc_width(input int ow, input int taps);
    return ow + $clog2(taps);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_seq_mac.sv
// +----------------------------------------------------------------------------+
// | fir_seq_mac                                                                 |
// | Registered unsigned multiply-accumulate with synchronous clear and enable.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module fir_seq_mac
  import fir_seq_pkg::*;
#(
  parameter int DW    = DEFAULT_DW,
  parameter int CW    = DEFAULT_CW,
  parameter int ACC_W = acc_width(DEFAULT_OW, DEFAULT_TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    sample,
  input  logic [CW-1:0]    coef,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [DW+CW-1:0]   prod;

  // acc is the running total including this cycle's product, so the final
  // tap's sum is available in the same cycle it is computed.
  always_comb begin
    prod  = (DW+CW)'(sample) * (DW+CW)'(coef);
    acc   = acc_q + ACC_W'(prod);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
// +----------------------------------------------------------------------------+
// | fir_mac_sequencer                                                           |
// | Time-multiplexed FIR: one shared MAC walks TAPS taps per input sample.      |
// | Option: FIR_SEQ_SAT_EN saturates Yout instead of wrapping modulo 2^OW.      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int TAPS = DEFAULT_TAPS,
  parameter int DW   = DEFAULT_DW,
  parameter int CW   = DEFAULT_CW,
  parameter int OW   = DEFAULT_OW
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           Xin,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [CW-1:0]           coef_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OW-1:0]           Yout,
  output logic                    busy
);

  localparam int              AW    = $clog2(TAPS);
  localparam int              ACC_W = acc_width(OW, TAPS);
  localparam logic [AW-1:0]   LAST  = AW'(TAPS - 1);
  localparam logic [ACC_W-1:0] Y_MAX = {{(ACC_W-OW){1'b0}}, {OW{1'b1}}};

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    k_q, k_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]    x_q [TAPS];
  logic [DW-1:0]    x_d [TAPS];
  logic [CW-1:0]    h_q [TAPS];
  logic [CW-1:0]    h_d [TAPS];
  logic [OW-1:0]    y_q, y_d;
  logic             out_valid_q, out_valid_d;

  logic             mac_clr;
  logic             mac_en;
  logic [ACC_W-1:0] acc_sum;
  logic [OW-1:0]    y_reduced;

  fir_seq_mac #(
    .DW    (DW),
    .CW    (CW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (Clk),
    .rst    (Rst),
    .clr    (mac_clr),
    .en     (mac_en),
    .sample (x_q[rd_ptr_q]),
    .coef   (h_q[k_q]),
    .acc    (acc_sum)
  );

  always_comb begin
`ifdef FIR_SEQ_SAT_EN
    y_reduced = (acc_sum > Y_MAX) ? {OW{1'b1}} : OW'(acc_sum);
`else
    y_reduced = OW'(acc_sum & Y_MAX);
`endif
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    x_d         = x_q;
    h_d         = h_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;

    // The MAC reads H only from the next cycle on, so a write coincident
    // with an accept is already visible to that sample.
    if (state_q == ST_IDLE && coef_we && int'(coef_addr) < TAPS) begin
      h_d[coef_addr] = coef_wdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d[wr_ptr_q] = Xin;
          wr_ptr_d      = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
          rd_ptr_d      = wr_ptr_q;
          k_d           = '0;
          mac_clr       = 1'b1;
          state_d       = ST_MAC;
        end
      end
      ST_MAC: begin
        mac_en   = 1'b1;
        k_d      = k_q + 1'b1;
        rd_ptr_d = (rd_ptr_q == '0) ? LAST : rd_ptr_q - 1'b1;
        if (k_q == LAST) begin
          k_d         = '0;
          y_d         = y_reduced;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      x_q         <= '{default: '0};
      h_q         <= '{default: '0};
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      x_q         <= x_d;
      h_q         <= h_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_MAC);
  assign out_valid = out_valid_q;
  assign Yout      = y_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_fir_mac_sequencer                                                        |
// | Directed and randomized checks against an arithmetic FIR reference model.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fir_mac_sequencer;

  localparam int TAPS = 3;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int OW   = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] xin;
  logic          coef_we;
  logic [1:0]    coef_addr;
  logic [CW-1:0] coef_wdata;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] yout;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Reference model: hist[0] is the newest sample, hm[k] is H[k].
  int unsigned hist [TAPS];
  int unsigned hm   [TAPS];

  fir_mac_sequencer #(
    .TAPS (TAPS),
    .DW   (DW),
    .CW   (CW),
    .OW   (OW)
  ) dut (
    .Clk        (clk),
    .Rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Xin        (xin),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Yout       (yout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < TAPS; i++) begin
      hist[i] = 0;
      hm[i]   = 0;
    end
  endfunction

  function automatic void model_push(input int unsigned x);
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
  endfunction

  function automatic int unsigned model_y();
    int unsigned s = 0;
    for (int k = 0; k < TAPS; k++) s += hm[k] * hist[k];
`ifdef FIR_SEQ_SAT_EN
    return (s > 65535) ? 65535 : s;
`else
    return s % 65536;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic coef_write(input int addr, input int data);
    coef_we    = 1'b1;
    coef_addr  = addr[1:0];
    coef_wdata = data[7:0];
    tick();
    coef_we = 1'b0;
    if (addr < TAPS) hm[addr] = data;
  endtask

  // cw_mode: 0 none, 1 coef write coincident with accept, 2 coef write in MAC.
  task automatic do_sample(input int x, input int hold, input int cw_mode,
                           input int cw_addr, input int cw_data);
    int unsigned exp_y;
    in_valid  = 1'b1;
    xin       = x[7:0];
    out_ready = (hold == 0);
    if (cw_mode == 1) begin
      coef_we    = 1'b1;
      coef_addr  = cw_addr[1:0];
      coef_wdata = cw_data[7:0];
      if (cw_addr < TAPS) hm[cw_addr] = cw_data;
    end
    chk("in_ready_idle", in_ready, 1);
    tick();
    coef_we = 1'b0;
    model_push(x);
    exp_y = model_y();
    for (int e = 0; e < TAPS; e++) begin
      chk("busy_mac", busy, 1);
      chk("in_ready_mac", in_ready, 0);
      chk("out_valid_mac", out_valid, 0);
      in_valid = 1'($urandom_range(0, 1));
      xin      = 8'($urandom);
      if (e == 0 && cw_mode == 2) begin
        coef_we    = 1'b1;
        coef_addr  = cw_addr[1:0];
        coef_wdata = cw_data[7:0];
      end
      tick();
      coef_we = 1'b0;
    end
    in_valid = 1'b0;
    chk("out_valid_rise", out_valid, 1);
    chk("yout", yout, exp_y);
    chk("busy_hold", busy, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_yout", yout, exp_y);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    xin        = '0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    out_ready  = 1'b1;
    model_clear();

    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_yout", yout, 0);
    chk("rst_busy", busy, 0);

    // Basic filtering with H={1,2,3}
    coef_write(0, 1);
    coef_write(1, 2);
    coef_write(2, 3);
    do_sample(1, 0, 0, 0, 0);
    do_sample(2, 0, 0, 0, 0);
    do_sample(3, 0, 0, 0, 0);

    // Backpressure
    do_sample(4, 5, 0, 0, 0);

    // Coef write in MAC ignored; coincident with accept used
    do_sample(5, 0, 2, 0, 9);
    do_sample(6, 0, 1, 0, 9);

    // Out-of-range coefficient address
    coef_write(3, 77);
    do_sample(8, 1, 0, 0, 0);

    // Reset during MAC discards the result and clears H
    in_valid = 1'b1;
    xin      = 8'd10;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_yout", yout, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    for (int i = 0; i < TAPS + 1; i++) begin
      tick();
      chk("midrst_no_pulse", out_valid, 0);
    end
    do_sample(7, 0, 0, 0, 0);

    // Overflow case
    do_reset();
    for (int k = 0; k < TAPS; k++) coef_write(k, 255);
    for (int i = 0; i < TAPS; i++) do_sample(255, 0, 0, 0, 0);

    // Randomized run covering several write-pointer wraps
    do_reset();
    for (int k = 0; k < TAPS; k++) coef_write(k, int'($urandom_range(0, 255)));
    for (int i = 0; i < 14; i++) begin
      do_sample(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
